// File: rtl/cla_mp_sequencer.sv
// Multi-precision add/subtract sequencer: walks NWORDS operand words LSW-first
// through one WIDTH-bit carry-lookahead adder, chaining carry between cycles.

module cla #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
);
   logic [WIDTH-1:0] gen;
   logic [WIDTH-1:0] prop;
   logic [WIDTH:0]   c;
   logic             gacc;
   logic             pacc;

   assign gen  = a_i & b_i;
   assign prop = a_i ^ b_i;

   // 4-bit lookahead groups; each group carry is derived from its group-in carry only
   always_comb begin
      c    = '0;
      gacc = 1'b0;
      pacc = 1'b1;
      c[0] = cin_i;
      for (int gi = 0; gi < WIDTH / 4; gi++) begin
         gacc = 1'b0;
         pacc = 1'b1;
         for (int k = 0; k < 4; k++) begin
            gacc             = gen[4*gi+k] | (prop[4*gi+k] & gacc);
            pacc             = prop[4*gi+k] & pacc;
            c[4*gi+k+1]      = gacc | (pacc & c[4*gi]);
         end
      end
   end

   assign sum_o  = prop ^ c[WIDTH-1:0];
   assign cout_o = c[WIDTH];
endmodule

// state | meaning
// IDLE  | waiting for start
// RUN   | one word per cycle through the adder, idx_q selects the word
// DONE  | one-cycle done pulse; start here is accepted back-to-back
module cla_mp_sequencer #(
   parameter int WIDTH  = 32,
   parameter int NWORDS = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start_i,
   input  logic                      sub_i,
   input  logic [NWORDS*WIDTH-1:0]   a_i,
   input  logic [NWORDS*WIDTH-1:0]   b_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [NWORDS*WIDTH-1:0]   result_o,
   output logic                      cout_o,
   output logic                      ovf_o
);
   localparam int IDX_W = $clog2(NWORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                    state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic                      carry_q, carry_d;
   logic                      sub_q, sub_d;
   logic [NWORDS*WIDTH-1:0]   a_q, a_d;
   logic [NWORDS*WIDTH-1:0]   b_q, b_d;
   logic [NWORDS*WIDTH-1:0]   result_q, result_d;
   logic                      cout_q, cout_d;
   logic                      ovf_q, ovf_d;

   logic [WIDTH-1:0]          a_word;
   logic [WIDTH-1:0]          b_word;
   logic [WIDTH-1:0]          sum_word;
   logic                      add_cout;

   assign a_word = a_q[idx_q*WIDTH +: WIDTH];
   assign b_word = b_q[idx_q*WIDTH +: WIDTH] ^ {WIDTH{sub_q}};

   cla #(.WIDTH(WIDTH)) u_cla (
      .a_i   (a_word),
      .b_i   (b_word),
      .cin_i (carry_q),
      .sum_o (sum_word),
      .cout_o(add_cout)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         sub_q    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         sub_q    <= sub_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      sub_d    = sub_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;

      case (state_q)
         RUN: begin
            result_d[idx_q*WIDTH +: WIDTH] = sum_word;
            carry_d = add_cout;
            if (idx_q == LAST_IDX) begin
               cout_d  = add_cout;
               ovf_d   = (a_word[WIDTH-1] == b_word[WIDTH-1]) &&
                         (sum_word[WIDTH-1] != a_word[WIDTH-1]);
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: begin
            // IDLE and DONE accept start identically; DONE otherwise falls back to IDLE
            if (state_q == DONE) state_d = IDLE;
            if (start_i) begin
               a_d      = a_i;
               b_d      = b_i;
               sub_d    = sub_i;
               idx_d    = '0;
               carry_d  = sub_i;
               result_d = '0;
               cout_d   = 1'b0;
               ovf_d    = 1'b0;
               state_d  = RUN;
            end
         end
      endcase
   end

   assign busy_o   = (state_q == RUN);
   assign done_o   = (state_q == DONE);
   assign result_o = result_q;
   assign cout_o   = cout_q;
   assign ovf_o    = ovf_q;
endmodule
